lsu_mem_resp: RTL and testbench

- Data-memory responder that sits between the EX stage and the data memory bus.
- Consumes the EX-stage memory request signals (mem_rd_en/addr_mem_rd, mem_wr_en/addr_mem_wr/data_mem_wr, load_code/store_code).
- Runs one multi-cycle bus transaction per request, stalling the pipeline while it runs.
- Returns sign- or zero-extended load data to MEM/WB and flags misaligned accesses without touching the bus.

---
 rtl/lsu_mem_resp_pkg.sv | 94 +++++++++
 rtl/lsu_mem_resp_load_ext.sv | 27 ++
 rtl/lsu_mem_resp.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_resp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_resp_pkg.sv
// Shared encodings, widths and decode helpers for the LSU data-memory responder.
package lsu_mem_resp_pkg;

  localparam int unsigned LSU_ADDR_W   = 64;
  localparam int unsigned LSU_DATA_W   = 64;
  localparam int unsigned BUS_WSTRB_W  = 8;
  localparam int unsigned BUS_L_CODE_W = 3;
  localparam int unsigned BUS_S_CODE_W = 3;
  localparam int unsigned OFF_W        = 3;

  localparam logic MEM_RD_EN = 1'b1;
  localparam logic MEM_WR_EN = 1'b1;

  localparam logic [BUS_L_CODE_W-1:0] INSTR_LB  = 3'b000;
  localparam logic [BUS_L_CODE_W-1:0] INSTR_LH  = 3'b001;
  localparam logic [BUS_L_CODE_W-1:0] INSTR_LW  = 3'b010;
  localparam logic [BUS_L_CODE_W-1:0] INSTR_LD  = 3'b011;
  localparam logic [BUS_L_CODE_W-1:0] INSTR_LBU = 3'b100;
  localparam logic [BUS_L_CODE_W-1:0] INSTR_LHU = 3'b101;
  localparam logic [BUS_L_CODE_W-1:0] INSTR_LWU = 3'b110;

  localparam logic [BUS_S_CODE_W-1:0] INSTR_SB = 3'b000;
  localparam logic [BUS_S_CODE_W-1:0] INSTR_SH = 3'b001;
  localparam logic [BUS_S_CODE_W-1:0] INSTR_SW = 3'b010;
  localparam logic [BUS_S_CODE_W-1:0] INSTR_SD = 3'b011;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  // Write-side bus payload, held stable for the whole request phase
  typedef struct packed {
    logic                         we;
    logic [BUS_WSTRB_W-1:0]       wstrb;
    logic [LSU_DATA_W-1:0]        wdata;
  } bus_payload_t;

  function automatic logic load_code_ok(input logic [BUS_L_CODE_W-1:0] c);
    return (c == INSTR_LB) || (c == INSTR_LH) || (c == INSTR_LW) || (c == INSTR_LD) ||
           (c == INSTR_LBU) || (c == INSTR_LHU) || (c == INSTR_LWU);
  endfunction

  function automatic logic store_code_ok(input logic [BUS_S_CODE_W-1:0] c);
    return (c == INSTR_SB) || (c == INSTR_SH) || (c == INSTR_SW) || (c == INSTR_SD);
  endfunction

  function automatic lsu_size_e load_size(input logic [BUS_L_CODE_W-1:0] c);
    lsu_size_e s;
    case (c)
      INSTR_LB, INSTR_LBU: s = SIZE_B;
      INSTR_LH, INSTR_LHU: s = SIZE_H;
      INSTR_LW, INSTR_LWU: s = SIZE_W;
      default:             s = SIZE_D;
    endcase
    return s;
  endfunction

  function automatic lsu_size_e store_size(input logic [BUS_S_CODE_W-1:0] c);
    return lsu_size_e'(c[1:0]);
  endfunction

  function automatic logic misaligned(input lsu_size_e s, input logic [OFF_W-1:0] off);
    logic m;
    case (s)
      SIZE_H:  m = off[0];
      SIZE_W:  m = |off[1:0];
      SIZE_D:  m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [BUS_WSTRB_W-1:0] size_strb(input lsu_size_e s);
    logic [BUS_WSTRB_W-1:0] b;
    case (s)
      SIZE_B:  b = 8'h01;
      SIZE_H:  b = 8'h03;
      SIZE_W:  b = 8'h0F;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lsu_mem_resp_load_ext.sv
// Lane extraction and sign/zero extension of a read doubleword.
module lsu_load_ext
  import lsu_mem_resp_pkg::*;
(
  input  logic [LSU_DATA_W-1:0]   rdata,
  input  logic [OFF_W-1:0]        offset,
  input  logic [BUS_L_CODE_W-1:0] load_code,
  output logic [LSU_DATA_W-1:0]   data_c
);

  logic [LSU_DATA_W-1:0] raw;

  // Right-justify the addressed lane, then extend by access type
  always_comb begin
    raw = rdata >> {offset, 3'b000};
    case (load_code)
      INSTR_LB:  data_c = {{56{raw[7]}},  raw[7:0]};
      INSTR_LH:  data_c = {{48{raw[15]}}, raw[15:0]};
      INSTR_LW:  data_c = {{32{raw[31]}}, raw[31:0]};
      INSTR_LBU: data_c = {56'd0, raw[7:0]};
      INSTR_LHU: data_c = {48'd0, raw[15:0]};
      INSTR_LWU: data_c = {32'd0, raw[31:0]};
      default:   data_c = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_resp.sv
// Data-memory responder: one stalled bus transaction per EX-stage load/store.
module lsu_mem_resp
  import lsu_mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = LSU_ADDR_W,
  parameter int unsigned DATA_W = LSU_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_rd_en,
  input  logic [ADDR_W-1:0]       addr_mem_rd,
  input  logic [BUS_L_CODE_W-1:0] load_code,
  input  logic                    mem_wr_en,
  input  logic [ADDR_W-1:0]       addr_mem_wr,
  input  logic [DATA_W-1:0]       data_mem_wr,
  input  logic [BUS_S_CODE_W-1:0] store_code,
  output logic                    mem_busy,
  output logic [DATA_W-1:0]       load_data,
  output logic                    load_valid,
  output logic                    misalign_err,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  output logic [BUS_WSTRB_W-1:0]  bus_wstrb,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [DATA_W-1:0]       bus_rdata
);

  lsu_state_e                state_q, state_d;
  logic                      req_q, req_d;
  bus_payload_t              pay_q, pay_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [OFF_W-1:0]          off_q, off_d;
  logic [BUS_L_CODE_W-1:0]   lcode_q, lcode_d;
  logic [DATA_W-1:0]         load_data_q, load_data_d;
  logic                      load_valid_q, load_valid_d;
  logic                      misalign_q, misalign_d;

  logic                      st_sel, ld_sel, req_vld, req_mis;
  logic [ADDR_W-1:0]         req_addr;
  logic [OFF_W-1:0]          req_off;
  lsu_size_e                 req_size;
  logic [DATA_W-1:0]         ext_data_c;

  lsu_load_ext u_load_ext (
    .rdata     (bus_rdata),
    .offset    (off_q),
    .load_code (lcode_q),
    .data_c    (ext_data_c)
  );

  // Decode the EX request; a store wins when both enables are high
  always_comb begin
    st_sel   = (mem_wr_en == MEM_WR_EN);
    ld_sel   = (mem_rd_en == MEM_RD_EN) && !st_sel;
    req_vld  = st_sel ? store_code_ok(store_code) : (ld_sel && load_code_ok(load_code));
    req_addr = st_sel ? addr_mem_wr : addr_mem_rd;
    req_off  = req_addr[OFF_W-1:0];
    req_size = st_sel ? store_size(store_code) : load_size(load_code);
    req_mis  = misaligned(req_size, req_off);
  end

  // Next-state, stall and registered-output computation
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    pay_d        = pay_q;
    addr_d       = addr_q;
    off_d        = off_q;
    lcode_d      = lcode_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = 1'b0;
    mem_busy     = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (req_vld && req_mis) begin
          misalign_d = 1'b1;
        end else if (req_vld) begin
          mem_busy    = 1'b1;
          state_d     = LSU_REQ;
          req_d       = 1'b1;
          addr_d      = {req_addr[ADDR_W-1:OFF_W], 3'b000};
          off_d       = req_off;
          lcode_d     = load_code;
          pay_d.we    = st_sel;
          pay_d.wdata = st_sel ? (data_mem_wr << {req_off, 3'b000}) : '0;
          pay_d.wstrb = st_sel ? BUS_WSTRB_W'(size_strb(req_size) << req_off) : '0;
        end
      end
      LSU_REQ: begin
        mem_busy = 1'b1;
        if (bus_gnt) begin
          req_d   = 1'b0;
          state_d = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        mem_busy = 1'b1;
        if (bus_rvalid) begin
          state_d = LSU_DONE;
          if (!pay_q.we) begin
            load_data_d  = ext_data_c;
            load_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSU_IDLE;
      req_q        <= 1'b0;
      pay_q        <= '0;
      addr_q       <= '0;
      off_q        <= '0;
      lcode_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pay_q        <= pay_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      lcode_q      <= lcode_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus_req      = req_q;
  assign bus_we       = pay_q.we;
  assign bus_addr     = addr_q;
  assign bus_wdata    = pay_q.wdata;
  assign bus_wstrb    = pay_q.wstrb;
  assign load_data    = load_data_q;
  assign load_valid   = load_valid_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_lsu_mem_resp.sv
// Self-checking bench for lsu_mem_resp with a load-data scoreboard.
module tb_lsu_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        mem_rd_en;
  logic [63:0] addr_mem_rd;
  logic [2:0]  load_code;
  logic        mem_wr_en;
  logic [63:0] addr_mem_wr;
  logic [63:0] data_mem_wr;
  logic [2:0]  store_code;
  logic        mem_busy;
  logic [63:0] load_data;
  logic        load_valid;
  logic        misalign_err;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LD = 3'b011;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101, LWU = 3'b110, LBAD = 3'b111;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010, SD = 3'b011;

  lsu_mem_resp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rd_en    (mem_rd_en),
    .addr_mem_rd  (addr_mem_rd),
    .load_code    (load_code),
    .mem_wr_en    (mem_wr_en),
    .addr_mem_wr  (addr_mem_wr),
    .data_mem_wr  (data_mem_wr),
    .store_code   (store_code),
    .mem_busy     (mem_busy),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_err (misalign_err),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    addr_mem_rd = '0;
    addr_mem_wr = '0;
    data_mem_wr = '0;
    load_code   = LD;
    store_code  = SD;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   64'(bus_req), 64'd0);
    chk({tag, "_we"},    64'(bus_we), 64'd0);
    chk({tag, "_lv"},    64'(load_valid), 64'd0);
    chk({tag, "_mis"},   64'(misalign_err), 64'd0);
    chk({tag, "_addr"},  bus_addr, 64'd0);
    chk({tag, "_wdata"}, bus_wdata, 64'd0);
    chk({tag, "_ldata"}, load_data, 64'd0);
    chk({tag, "_wstrb"}, 64'(bus_wstrb), 64'd0);
  endtask

  // Scoreboard: every load_valid pulse must match the oldest expected load
  always @(negedge clk) begin
    if (load_valid) begin
      if (sb_q.size() == 0) begin
        chk("lv_spurious", 64'd1, 64'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("ld_data", load_data, sb_exp);
      end
    end
  end

  // One full transaction; called at the start of an IDLE cycle, returns at the next IDLE cycle
  task automatic run_txn(input bit st, input bit both, input logic [2:0] code,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                         input logic [63:0] exp_ld, input logic [7:0] exp_strb,
                         input logic [63:0] exp_wdata, input int gnt_wait);
    logic [63:0] exp_addr;
    exp_addr = {addr[63:3], 3'b000};
    if (st) begin
      mem_wr_en = 1'b1; addr_mem_wr = addr; data_mem_wr = wd; store_code = code;
      if (both) begin
        mem_rd_en = 1'b1; addr_mem_rd = 64'h7777; load_code = LD;
      end
    end else begin
      mem_rd_en = 1'b1; addr_mem_rd = addr; load_code = code;
      sb_q.push_back(exp_ld);
    end
    #1;
    chk("busy_accept", 64'(mem_busy), 64'd1);
    step();
    chk("req_hi", 64'(bus_req), 64'd1);
    chk("req_we", 64'(bus_we), 64'(st));
    chk("req_addr", bus_addr, exp_addr);
    if (st) begin
      chk("req_wstrb", 64'(bus_wstrb), 64'(exp_strb));
      chk("req_wdata", bus_wdata, exp_wdata);
    end
    for (int i = 0; i < gnt_wait; i++) begin
      step();
      chk("stall_req", 64'(bus_req), 64'd1);
      chk("stall_busy", 64'(mem_busy), 64'd1);
      chk("stall_addr", bus_addr, exp_addr);
      chk("stall_we", 64'(bus_we), 64'(st));
      if (st) begin
        chk("stall_wstrb", 64'(bus_wstrb), 64'(exp_strb));
        chk("stall_wdata", bus_wdata, exp_wdata);
      end
    end
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("wait_req", 64'(bus_req), 64'd0);
    chk("wait_busy", 64'(mem_busy), 64'd1);
    chk("wait_lv", 64'(load_valid), 64'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = rd;
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
    chk("done_busy", 64'(mem_busy), 64'd0);
    chk("done_lv", 64'(load_valid), 64'(!st));
    step();
    idle_inputs();
  endtask

  // Misaligned request held for one cycle only
  task automatic run_mis(input bit st, input logic [2:0] code, input logic [63:0] addr);
    if (st) begin
      mem_wr_en = 1'b1; addr_mem_wr = addr; store_code = code; data_mem_wr = 64'h55;
    end else begin
      mem_rd_en = 1'b1; addr_mem_rd = addr; load_code = code;
    end
    #1;
    chk("mis_busy", 64'(mem_busy), 64'd0);
    step();
    idle_inputs();
    #1;
    chk("mis_pulse", 64'(misalign_err), 64'd1);
    chk("mis_req", 64'(bus_req), 64'd0);
    step();
    chk("mis_clear", 64'(misalign_err), 64'd0);
    chk("mis_req2", 64'(bus_req), 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    idle_inputs();
    #1;
    chk_reset_outputs("rst");
    chk("rst_busy", 64'(mem_busy), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Loads with minimal latency
    run_txn(1'b0, 1'b0, LD,  64'h1000, '0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, '0, '0, 0);
    run_txn(1'b0, 1'b0, LB,  64'h1007, '0, 64'h80FF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FF80, '0, '0, 0);
    run_txn(1'b0, 1'b0, LBU, 64'h1007, '0, 64'h80FF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0080, '0, '0, 0);
    run_txn(1'b0, 1'b0, LH,  64'h1006, '0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, '0, '0, 1);
    run_txn(1'b0, 1'b0, LHU, 64'h1002, '0, 64'h0000_0000_9ABC_0000, 64'h0000_0000_0000_9ABC, '0, '0, 0);
    run_txn(1'b0, 1'b0, LW,  64'h1004, '0, 64'hF000_0001_0000_0000, 64'hFFFF_FFFF_F000_0001, '0, '0, 0);
    run_txn(1'b0, 1'b0, LWU, 64'h1004, '0, 64'hF000_0001_0000_0000, 64'h0000_0000_F000_0001, '0, '0, 2);

    // Stores, including a long grant stall and both enables high
    run_txn(1'b1, 1'b0, SH, 64'h2002, 64'hBEEF, '0, '0, 8'h0C, 64'h0000_0000_BEEF_0000, 4);
    run_txn(1'b1, 1'b1, SB, 64'h2005, 64'hAB,   '0, '0, 8'h20, 64'h0000_AB00_0000_0000, 0);
    run_txn(1'b1, 1'b0, SW, 64'h2004, 64'h1122_3344, '0, '0, 8'hF0, 64'h1122_3344_0000_0000, 1);

    // Misaligned accesses, then a normal aligned request
    run_mis(1'b0, LW, 64'h3002);
    run_txn(1'b0, 1'b0, LW, 64'h3004, '0, 64'h1234_5678_0000_0000, 64'h0000_0000_1234_5678, '0, '0, 0);
    run_mis(1'b1, SD, 64'h4004);
    run_mis(1'b0, LH, 64'h4001);

    // Unknown load code is no request at all
    mem_rd_en = 1'b1; addr_mem_rd = 64'h4000; load_code = LBAD;
    #1;
    chk("bad_busy", 64'(mem_busy), 64'd0);
    step();
    idle_inputs();
    chk("bad_req", 64'(bus_req), 64'd0);
    chk("bad_mis", 64'(misalign_err), 64'd0);
    step();

    // Reset while waiting for completion; a late rvalid must be ignored
    mem_rd_en = 1'b1; addr_mem_rd = 64'h6000; load_code = LD;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk("abort_inwait", 64'(mem_busy), 64'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk_reset_outputs("abort");
    chk("abort_busy", 64'(mem_busy), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    bus_rvalid = 1'b1;
    bus_rdata  = 64'h1111_2222_3333_4444;
    #1;
    chk("stray_busy", 64'(mem_busy), 64'd0);
    step();
    bus_rvalid = 1'b0;
    chk("stray_lv", 64'(load_valid), 64'd0);
    chk("stray_req", 64'(bus_req), 64'd0);
    chk("stray_ldata", load_data, 64'd0);
    step();
    chk("stray_lv2", 64'(load_valid), 64'd0);

    // Back-to-back store then load to the same doubleword
    run_txn(1'b1, 1'b0, SD, 64'h5000, 64'hDEAD_BEEF_CAFE_F00D, '0, '0, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0);
    run_txn(1'b0, 1'b0, LD, 64'h5000, '0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, '0, '0, 0);
    chk("hold_ldata", load_data, 64'hDEAD_BEEF_CAFE_F00D);
    step();
    chk("idle_after", 64'(bus_req), 64'd0);
    chk("hold_ldata2", load_data, 64'hDEAD_BEEF_CAFE_F00D);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
